data_mem_burst_master: RTL and testbench

Load/store burst engine on the execute side of the pipeline that drives one read port and one write port of the data memory. It accepts a single request of 1–4 consecutive 32-bit words from the execute stage. It returns read data beat by beat, or consumes write data beat by beat, through valid/ready handshakes. Memory ports 1 are owned by this block; ports 2–4 remain available to other masters.

---
 rtl/data_mem_burst_master.sv | 140 ++++++++++++++
 tb/tb_data_mem_burst_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_burst_master.sv
// Execute-side load/store burst engine: 1-4 word bursts on data memory port 1.
// Define LSU_BOUNDS_CHECK_EN to reject bursts that would run past the top address.
module data_mem_burst_master #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] data_rd1,
  input  logic [DATA_W-1:0] data_rd1_out,
  output logic [ADDR_W-1:0] data_wr1,
  output logic [DATA_W-1:0] data_wr1_data,
  output logic              data_wr1_enable
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [2:0]        rem, rem_n;
  logic              rv_n, rl_n, re_n;
  logic [DATA_W-1:0] rd_n;
  logic              err_q;
  logic              oob;

`ifdef LSU_BOUNDS_CHECK_EN
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, req_addr}
                  + {{(ADDR_W-1){1'b0}}, req_len};
  assign oob = end_addr[ADDR_W];
  assign rsp_err = err_q;
`else
  assign oob = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign wdata_ready = (state == WRITE);
  assign data_rd1 = addr;
  assign data_wr1 = (state == WRITE) ? addr : '0;
  assign data_wr1_data = (state == WRITE) ? wdata : '0;
  assign data_wr1_enable = (state == WRITE) && wdata_valid;

  always_comb begin
    state_n = state;
    addr_n = addr;
    rem_n = rem;
    rv_n = rsp_valid;
    rd_n = rsp_data;
    rl_n = rsp_last;
    re_n = err_q;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          addr_n = req_addr;
          rem_n = {1'b0, req_len} + 3'd1;
          re_n = 1'b0;
          state_n = req_write ? WRITE : READ;
          if (oob) begin
            state_n = RESP;
            rv_n = 1'b1;
            rl_n = 1'b1;
            rd_n = '0;
            re_n = 1'b1;
          end
        end
      end
      READ: begin
        if (!rsp_valid || rsp_ready) begin
          rv_n = 1'b1;
          rd_n = data_rd1_out;
          rl_n = (rem == 3'd1);
          addr_n = addr + ADDR_W'(1);
          rem_n = rem - 3'd1;
          if (rem == 3'd1) state_n = RESP;
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          addr_n = addr + ADDR_W'(1);
          rem_n = rem - 3'd1;
          if (rem == 3'd1) begin
            rv_n = 1'b1;
            rl_n = 1'b1;
            rd_n = '0;
            state_n = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_n = 1'b0;
          rl_n = 1'b0;
          re_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      rem <= rem_n;
      rsp_valid <= rv_n;
      rsp_data <= rd_n;
      rsp_last <= rl_n;
      err_q <= re_n;
    end
  end

endmodule

// File: tb/tb_data_mem_burst_master.sv
// Directed bench for data_mem_burst_master with a queue-based response model.
// Handles both the default and the LSU_BOUNDS_CHECK_EN build.
module tb_data_mem_burst_master;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clock, reset;
  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [1:0]  req_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic [8:0]  data_rd1, data_wr1;
  logic [31:0] data_rd1_out, data_wr1_data;
  logic        data_wr1_enable;

  data_mem_burst_master #(.ADDR_W(9), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .data_rd1(data_rd1), .data_rd1_out(data_rd1_out),
    .data_wr1(data_wr1), .data_wr1_data(data_wr1_data),
    .data_wr1_enable(data_wr1_enable)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        e;
  } exp_t;

  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];
  exp_t exp_q [$];
  int tests = 0;
  int fails = 0;
  int strobes = 0;
  int pops = 0;
  bit tog = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  assign data_rd1_out = mem[data_rd1];

  always @(posedge clock) begin
    if (data_wr1_enable) begin
      mem[data_wr1] <= data_wr1_data;
      strobes <= strobes + 1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response-ready driver: steady high, or the 1,0,0,1 pattern
  initial begin
    int c = 0;
    rsp_ready = 1;
    forever begin
      @(posedge clock);
      #1;
      if (tog) rsp_ready = (c % 4 == 0) || (c % 4 == 3);
      else rsp_ready = 1;
      c++;
    end
  end

  // Compare process: checks each consumed beat and hold stability
  initial begin
    bit   hv = 0;
    exp_t h;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hv = 0;
      end else begin
        if (data_wr1_enable) chk("wr_en_in_write", wdata_ready, 1);
        if (rsp_valid) begin
          if (hv) begin
            chk("hold_data", rsp_data, h.d);
            chk("hold_last", rsp_last, h.l);
            chk("hold_err", rsp_err, h.e);
          end
          if (rsp_ready) begin
            hv = 0;
            pops++;
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_data", rsp_data, e.d);
              chk("rsp_last", rsp_last, e.l);
              chk("rsp_err", rsp_err, e.e);
            end
          end else begin
            hv = 1;
            h.d = rsp_data;
            h.l = rsp_last;
            h.e = rsp_err;
          end
        end else begin
          hv = 0;
        end
      end
    end
  end

  function automatic bit is_oob(int a, int l);
    return BC && (a + l > 511);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && !rsp_valid) && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("idle_timeout", n < 100, 1);
  endtask

  task automatic do_req(bit w, int a, int l);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1;
    req_write = w;
    req_addr = 9'(a);
    req_len = 2'(l);
    @(posedge clock);
    #1;
    req_valid = 0;
  endtask

  task automatic wr_burst(int a, int l, int base, bit gap);
    bit o = is_oob(a, l);
    exp_q.push_back('{32'h0, 1'b1, o});
    do_req(1, a, l);
    if (o) begin
      chk("oob_rsp_valid", rsp_valid, 1);
      chk("oob_wdata_ready", wdata_ready, 0);
    end else begin
      for (int i = 0; i <= l; i++) begin
        if (gap && i == 1) begin
          wdata_valid = 0;
          @(posedge clock);
          #1;
        end
        wdata_valid = 1;
        wdata = 32'(base + i);
        ref_mem[(a + i) % 512] = 32'(base + i);
        @(posedge clock);
        #1;
      end
      wdata_valid = 0;
      chk("wr_cpl_valid", rsp_valid, 1);
      chk("wr_cpl_last", rsp_last, 1);
    end
    wait_idle();
  endtask

  task automatic rd_burst(int a, int l);
    if (is_oob(a, l)) begin
      exp_q.push_back('{32'h0, 1'b1, 1'b1});
    end else begin
      for (int i = 0; i <= l; i++)
        exp_q.push_back('{ref_mem[(a + i) % 512], i == l, 1'b0});
    end
    do_req(0, a, l);
    wait_idle();
  endtask

  task automatic chk_mem(int a);
    chk($sformatf("mem_%0h", a), mem[a], ref_mem[a]);
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 512; i++) begin
      mem[i] = 0;
      ref_mem[i] = 0;
    end
    reset = 0;
    req_valid = 0;
    req_write = 0;
    req_addr = 0;
    req_len = 0;
    wdata_valid = 0;
    wdata = 0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_wr_en", data_wr1_enable, 0);
    @(posedge clock);
    #1;
    reset = 1;
    @(posedge clock);
    #1;

    // Reset during beat 2 of a 4-beat write
    do_req(1, 'h100, 3);
    for (int i = 0; i < 2; i++) begin
      wdata_valid = 1;
      wdata = 32'hB0 + 32'(i);
      ref_mem['h100 + i] = 32'hB0 + 32'(i);
      @(posedge clock);
      #1;
    end
    wdata = 32'hB2;
    chk("pre_rst_wr_en", data_wr1_enable, 1);
    reset = 0;
    #1;
    chk("mid_rst_wr_en", data_wr1_enable, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_wdata_ready", wdata_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rd1", data_rd1, 0);
    chk("mid_rst_wr1", data_wr1, 0);
    chk("mid_rst_wr1_data", data_wr1_data, 0);
    @(posedge clock);
    #1;
    wdata_valid = 0;
    reset = 1;
    exp_q.delete();
    @(posedge clock);
    #1;
    chk("rst_mem_b1", mem['h101], 32'hB1);
    chk("rst_mem_b2", mem['h102], 0);
    for (int i = 0; i < 4; i++) chk_mem('h100 + i);

    // Back-to-back write burst
    wr_burst('h010, 3, 'hA0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("wr_lit", mem['h010 + i], 32'hA0 + 32'(i));
      chk_mem('h010 + i);
    end

    // Read back with rsp_ready high: pinned timing and data
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{ref_mem['h010 + i], i == 3, 1'b0});
    do_req(0, 'h010, 3);
    chk("rd_lat_not_yet", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      chk("rd_beat_valid", rsp_valid, 1);
      chk("rd_beat_lit", rsp_data, 32'hA0 + 32'(i));
      chk("rd_last_lit", rsp_last, 32'(i == 3));
    end
    wait_idle();

    // Read with ready toggling 1,0,0,1
    s0 = pops;
    tog = 1;
    rd_burst('h010, 3);
    tog = 0;
    chk("tog_beats", pops - s0, 4);
    chk("tog_q_empty", exp_q.size(), 0);

    // Write with a wdata gap, then read back
    wr_burst('h020, 1, 'hD0, 1);
    chk("gap_mem", mem['h021], 32'hD1);
    rd_burst('h020, 1);

    // Write crossing the top of memory
    s0 = strobes;
    wr_burst('h1FE, 3, 'hC0, 0);
    if (BC) begin
      chk("oob_strobes", strobes - s0, 0);
    end else begin
      chk("wrap_strobes", strobes - s0, 4);
      chk("wrap_mem0", mem['h000], 32'hC2);
      chk("wrap_mem1", mem['h001], 32'hC3);
      chk("wrap_mem1fe", mem['h1FE], 32'hC0);
    end
    for (int i = 0; i < 4; i++) chk_mem(('h1FE + i) % 512);
    rd_burst('h1FF, 1);
    chk("final_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
